// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
// Shared definitions for the serial comparator controller and its 8-bit slice:
//   - state_t      : controller states (IDLE, RUN, FIN)
//   - CASC_*       : 3-bit cascade codes, bit order {igual, mayor, menor}
//   - NBYTES_DEF   : default operand width in bytes
//   - casc_pack    : packs the three cascade flags into one 3-bit word
// -----------------------------------------------------------------------------
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] CASC_IGUAL = 3'b100;
    localparam logic [2:0] CASC_MAYOR = 3'b010;
    localparam logic [2:0] CASC_MENOR = 3'b001;
    localparam logic [2:0] CASC_NONE  = 3'b000;

    localparam int NBYTES_DEF = 4;

    // Packs the individual cascade flags as {igual, mayor, menor}.
    function automatic logic [2:0] casc_pack(input logic igual,
                                             input logic mayor,
                                             input logic menor);
        return {igual, mayor, menor};
    endfunction

endpackage : comparador_pkg

// File: rtl/comparador_8bits.sv
// -----------------------------------------------------------------------------
// comparador_8bits  (the Comparador8bits cascadable slice)
// Purely combinational unsigned 8-bit magnitude comparator with cascade input.
// Unequal bytes decide the result on their own; equal bytes pass the cascade
// input through unchanged, including non-one-hot patterns.
// Ports:
//   a, b                       : 8-bit unsigned bytes to compare
//   igual_i, mayor_i, menor_i  : cascade-in from the less significant byte
//   igual_o, mayor_o, menor_o  : cascade-out / comparison result
// -----------------------------------------------------------------------------
module comparador_8bits
    import comparador_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       igual_i,
    input  logic       mayor_i,
    input  logic       menor_i,
    output logic       igual_o,
    output logic       mayor_o,
    output logic       menor_o
);

    logic [2:0] res_s;

    // Byte compare; the cascade only matters when the bytes are equal.
    always_comb begin
        res_s = CASC_NONE;
        if (a > b) begin
            res_s = CASC_MAYOR;
        end else if (a < b) begin
            res_s = CASC_MENOR;
        end else begin
            res_s = casc_pack(igual_i, mayor_i, menor_i);
        end
    end

    assign igual_o = res_s[2];
    assign mayor_o = res_s[1];
    assign menor_o = res_s[0];

endmodule : comparador_8bits

// File: rtl/comparador_serie_ctrl.sv
// -----------------------------------------------------------------------------
// comparador_serie_ctrl
// Compares two NBYTES-wide operands one byte per clock, LSB byte first, using a
// single shared comparador_8bits slice. The slice result is registered and fed
// back as the cascade input for the next more significant byte.
//
// Timing: start sampled at edge t -> RUN for NBYTES cycles -> FIN (done=1)
// in cycle t+NBYTES+1 -> IDLE. One compare per NBYTES+2 cycles.
//
// Optional build macro: COMPARADOR_SIGNO_EN adds a 'signo' input; when it is
// sampled high, bit 7 of the most significant byte of both operands is
// inverted at latch time, which turns the unsigned compare into a
// two's-complement compare.
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   start                      : request, only honoured in IDLE
//   a, b                       : operands, latched on accepted start
//   igual_i, mayor_i, menor_i  : external cascade-in, latched on accepted start
//   signo                      : (COMPARADOR_SIGNO_EN only) signed ordering
//   busy                       : high in RUN and FIN
//   done                       : one-cycle pulse, results valid
//   igual_o, mayor_o, menor_o  : registered results, held until next FIN/reset
// -----------------------------------------------------------------------------
module comparador_serie_ctrl
    import comparador_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  igual_i,
    input  logic                  mayor_i,
    input  logic                  menor_i,
`ifdef COMPARADOR_SIGNO_EN
    input  logic                  signo,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  igual_o,
    output logic                  mayor_o,
    output logic                  menor_o
);

    localparam int IDXW = $clog2(NBYTES);
    localparam int W    = 8 * NBYTES;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);
    // Selects bit 7 of the most significant byte.
    localparam logic [W-1:0] SIGN_MASK = {1'b1, {(W-1){1'b0}}};

    state_t           state_r;
    logic [IDXW-1:0]  idx_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [2:0]       casc_r;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       res_r;

    logic [7:0]       byte_a_s;
    logic [7:0]       byte_b_s;
    logic [2:0]       slice_s;
    logic             flip_s;

`ifdef COMPARADOR_SIGNO_EN
    assign flip_s = signo;
`else
    assign flip_s = 1'b0;
`endif

    // Byte mux: selects byte idx of each latched operand for the shared slice.
    always_comb begin
        byte_a_s = 8'h00;
        byte_b_s = 8'h00;
        byte_a_s = a_r[{idx_r, 3'b000} +: 8];
        byte_b_s = b_r[{idx_r, 3'b000} +: 8];
    end

    comparador_8bits u_slice (
        .a       (byte_a_s),
        .b       (byte_b_s),
        .igual_i (casc_r[2]),
        .mayor_i (casc_r[1]),
        .menor_i (casc_r[0]),
        .igual_o (slice_s[2]),
        .mayor_o (slice_s[1]),
        .menor_o (slice_s[0])
    );

    // Controller FSM with operand, cascade and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            casc_r  <= CASC_NONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            res_r   <= CASC_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Sign flip is folded in here so the slice stays unsigned.
                        a_r     <= flip_s ? (a ^ SIGN_MASK) : a;
                        b_r     <= flip_s ? (b ^ SIGN_MASK) : b;
                        casc_r  <= casc_pack(igual_i, mayor_i, menor_i);
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    casc_r <= slice_s;
                    if (idx_r == IDX_LAST) begin
                        // Results are loaded on the edge into FIN so they are
                        // already valid while done is high.
                        res_r   <= slice_s;
                        done_r  <= 1'b1;
                        state_r <= FIN;
                    end else begin
                        idx_r   <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                        state_r <= RUN;
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    idx_r   <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    idx_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign igual_o = res_r[2];
    assign mayor_o = res_r[1];
    assign menor_o = res_r[0];

endmodule : comparador_serie_ctrl

// File: tb/tb_comparador_serie_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comparador_serie_ctrl
// Self-checking bench: directed cases plus randomized operations compared
// against a whole-word reference model (plain integer comparison).
// -----------------------------------------------------------------------------
module tb_comparador_serie_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         igual_i;
    logic         mayor_i;
    logic         menor_i;
    logic         signo;
    logic         busy;
    logic         done;
    logic         igual_o;
    logic         mayor_o;
    logic         menor_o;

    int checks_cnt;
    int failures_cnt;

    comparador_serie_ctrl #(.NBYTES(NB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .igual_i (igual_i),
        .mayor_i (mayor_i),
        .menor_i (menor_i),
`ifdef COMPARADOR_SIGNO_EN
        .signo   (signo),
`endif
        .busy    (busy),
        .done    (done),
        .igual_o (igual_o),
        .mayor_o (mayor_o),
        .menor_o (menor_o)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word compare; equal words pass the cascade-in through.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic [2:0] cin, input logic sg);
        longint sa;
        longint sb;
        if (sg) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
        end else begin
            sa = longint'(av);
            sb = longint'(bv);
        end
        if (sa > sb)      return 3'b010;
        else if (sa < sb) return 3'b001;
        else              return cin;
    endfunction

    function automatic logic [2:0] outs();
        return {igual_o, mayor_o, menor_o};
    endfunction

    // One complete operation with latency, busy, done and result checks.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] cin, input logic sg, input string tag);
        logic [2:0] exp;
        int k;
        logic busy_ok;
        exp = ref_cmp(av, bv, cin, sg);
        @(negedge clk);
        a = av; b = bv; {igual_i, mayor_i, menor_i} = cin; signo = sg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: results must come from the latched values.
        a = $urandom; b = $urandom; {igual_i, mayor_i, menor_i} = 3'($urandom); signo = 1'($urandom);
        k = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check_eq({tag, ".lat"}, 32'(k), 32'(NB));
        check_eq({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, ".res"}, {29'd0, outs()}, {29'd0, exp});
        @(posedge clk); #1;
        check_eq({tag, ".done_pulse"}, {30'd0, done, busy}, 32'd0);
        check_eq({tag, ".hold"}, {29'd0, outs()}, {29'd0, exp});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rc;
        logic         rs;
        logic [2:0]   exp1;
        logic [2:0]   exp2;
        logic [2:0]   prev;
        int           k;
        int           dones;

        checks_cnt = 0; failures_cnt = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        igual_i = 1'b0; mayor_i = 1'b0; menor_i = 1'b0; signo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.state", {28'd0, busy, done, 2'b00}, 32'd0);
        check_eq("reset.outs", {29'd0, outs()}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases.
        run_op(32'h12345678, 32'h12345678, 3'b100, 1'b0, "eq");
        run_op(32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b0, "msb_u");
        run_op(32'h000000FA, 32'h000000FB, 3'b100, 1'b0, "lsb_u");
        run_op(32'h00000000, 32'h00000000, 3'b010, 1'b0, "casc_mayor");
        run_op(32'h00000000, 32'h00000000, 3'b000, 1'b0, "casc_none");
        run_op(32'hAB00CD00, 32'hAB00CD00, 3'b110, 1'b0, "casc_110");
        run_op(32'h01FFFFFF, 32'h02000000, 3'b010, 1'b0, "msb_dec");
`ifdef COMPARADOR_SIGNO_EN
        run_op(32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b1, "msb_s");
        run_op(32'hFFFFFFFA, 32'hFFFFFFFB, 3'b100, 1'b1, "neg_s");
        run_op(32'h00000001, 32'hFFFFFFFF, 3'b100, 1'b1, "pos_neg_s");
`endif

        // start held through RUN/FIN with operands changing mid-operation.
        exp1 = ref_cmp(32'h00000010, 32'h00000020, 3'b100, 1'b0);
        exp2 = ref_cmp(32'h90000000, 32'h10000000, 3'b100, 1'b0);
        @(negedge clk);
        a = 32'h00000010; b = 32'h00000020; {igual_i, mayor_i, menor_i} = 3'b100; signo = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        a = 32'h90000000; b = 32'h10000000;
        dones = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e == NB) begin
                check_eq("held.res1", {29'd0, done, 2'b00} | 32'(outs()), {29'd0, 1'b1, 2'b00} | 32'(exp1));
            end
            if (e == NB + 1) check_eq("held.idle_gap", {31'd0, busy}, 32'd0);
            if (e == NB + 2) start = 1'b0;
            if (e == 2 * NB + 2) begin
                check_eq("held.done2", {31'd0, done}, 32'd1);
                check_eq("held.res2", {29'd0, outs()}, {29'd0, exp2});
            end
            if (done === 1'b1) dones++;
        end
        check_eq("held.done_count", 32'(dones), 32'd2);

        // Reset in RUN cycle 2: operation abandoned.
        prev = outs();
        @(negedge clk);
        a = 32'h00000005; b = 32'h00000003; {igual_i, mayor_i, menor_i} = 3'b100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("rst.busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst.mid", {28'd0, busy, done, 2'b00}, 32'd0);
        check_eq("rst.outs", {29'd0, outs()}, 32'd0);
        k = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) k++;
        end
        check_eq("rst.no_done", 32'(k), 32'd0);
        if (prev == 3'b111) check_eq("rst.prev_dummy", 32'd0, 32'd0);
        run_op(32'h00000005, 32'h00000003, 3'b100, 1'b0, "after_rst");

        // Randomized operations; some bytes of b copied from a to hit cascade paths.
        for (int n = 0; n < 120; n++) begin
            ra = $urandom;
            rb = $urandom;
            for (int j = 0; j < NB; j++) begin
                if ($urandom_range(0, 3) != 0) rb[8*j +: 8] = ra[8*j +: 8];
            end
            if ($urandom_range(0, 7) == 0) rb = ra;
            rc = 3'($urandom);
`ifdef COMPARADOR_SIGNO_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule : tb_comparador_serie_ctrl
